// File: rtl/ctrl_teclado_eq_if.sv
// Receiver and coefficient-stage handshake bundle for the keyboard command sequencer.
// The master side is the sequencer; the slave side is the receiver/coefficient environment.
interface ctrl_teclado_eq_if #(
  parameter int G_W = 4
);
  logic           rx_done_tick;
  logic [7:0]     rx_data;
  logic           rx_en;
  logic           cfg_wr;
  logic [1:0]     cfg_band;
  logic [G_W-1:0] cfg_gain;
  logic           cfg_ack;

  modport master (
    input  rx_done_tick, rx_data, cfg_ack,
    output rx_en, cfg_wr, cfg_band, cfg_gain
  );

  modport slave (
    output rx_done_tick, rx_data, cfg_ack,
    input  rx_en, cfg_wr, cfg_band, cfg_gain
  );
endinterface

// File: rtl/ctrl_teclado_eq.sv
// Scan-code sequencer: decodes E0/F0-prefixed PS2 streams into run/stop, band select and
// saturating per-band gain steps, each step pushed to the coefficient stage via cfg_wr/cfg_ack.
module ctrl_teclado_eq #(
  parameter int G_W      = 4,
  parameter int GAIN_RST = 8,
  parameter int GAIN_MAX = 15,
  parameter int TIMEOUT  = 50000
) (
  input  logic                clk,
  input  logic                reset,
  ctrl_teclado_eq_if.master   bus,
  output logic                eq_run,
  output logic [1:0]          banda_sel,
  output logic [G_W-1:0]      ganancia_bajo,
  output logic [G_W-1:0]      ganancia_medio,
  output logic [G_W-1:0]      ganancia_alto,
  output logic                err_tick
);

  localparam int             CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [7:0] K_BRK   = 8'hF0;
  localparam logic [7:0] K_EXT   = 8'hE0;
  localparam logic [7:0] K_RUN   = 8'h43;
  localparam logic [7:0] K_STOP  = 8'h2C;
  localparam logic [7:0] K_BAJO  = 8'h16;
  localparam logic [7:0] K_MEDIO = 8'h1E;
  localparam logic [7:0] K_ALTO  = 8'h26;
  localparam logic [7:0] K_UP    = 8'h75;
  localparam logic [7:0] K_DOWN  = 8'h72;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    WAIT_ACK
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic           take;
  logic           is_up;
  logic           is_step;
  logic           at_limit;
  logic [G_W-1:0] cur_gain;
  logic [G_W-1:0] next_gain;

  // rx_en doubles as the consume qualifier, so a tick during WAIT_ACK never reaches the decoder.
  always_comb begin
    take    = bus.rx_done_tick && bus.rx_en;
    is_up   = (bus.rx_data == K_UP);
    is_step = is_up || (bus.rx_data == K_DOWN);
    case (banda_sel)
      2'd0:    cur_gain = ganancia_bajo;
      2'd1:    cur_gain = ganancia_medio;
      default: cur_gain = ganancia_alto;
    endcase
    at_limit  = is_up ? (cur_gain == G_W'(GAIN_MAX)) : (cur_gain == '0);
    next_gain = is_up ? (cur_gain + G_W'(1)) : (cur_gain - G_W'(1));
  end

  // NOTE: every register here uses <= so all branches see the pre-edge values of state and gains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      eq_run         <= 1'b0;
      banda_sel      <= 2'd0;
      ganancia_bajo  <= G_W'(GAIN_RST);
      ganancia_medio <= G_W'(GAIN_RST);
      ganancia_alto  <= G_W'(GAIN_RST);
      err_tick       <= 1'b0;
      bus.rx_en      <= 1'b0;
      bus.cfg_wr     <= 1'b0;
      bus.cfg_band   <= 2'd0;
      bus.cfg_gain   <= '0;
    end else begin
      bus.cfg_wr <= 1'b0;
      err_tick   <= 1'b0;

      case (state)
        IDLE: begin
          bus.rx_en <= 1'b1;
          cnt       <= '0;
          if (take) begin
            case (bus.rx_data)
              K_BRK:   state     <= BRK;
              K_EXT:   state     <= EXT;
              K_RUN:   eq_run    <= 1'b1;
              K_STOP:  eq_run    <= 1'b0;
              K_BAJO:  banda_sel <= 2'd0;
              K_MEDIO: banda_sel <= 2'd1;
              K_ALTO:  banda_sel <= 2'd2;
              default: err_tick  <= 1'b1;
            endcase
          end
        end

        EXT, BRK, EXT_BRK: begin
          if (!take) begin
            if (cnt == CNT_LAST) begin
              state    <= IDLE;
              err_tick <= 1'b1;
              cnt      <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            // Break-prefixed bytes fall through to IDLE here; only EXT overrides the target.
            cnt   <= '0;
            state <= IDLE;
            if (state == EXT) begin
              if (is_step) begin
                if (eq_run && !at_limit) begin
                  case (banda_sel)
                    2'd0:    ganancia_bajo  <= next_gain;
                    2'd1:    ganancia_medio <= next_gain;
                    default: ganancia_alto  <= next_gain;
                  endcase
                  bus.cfg_wr   <= 1'b1;
                  bus.cfg_band <= banda_sel;
                  bus.cfg_gain <= next_gain;
                  bus.rx_en    <= 1'b0;
                  state        <= WAIT_ACK;
                end
              end else if (bus.rx_data == K_BRK) begin
                state <= EXT_BRK;
              end else begin
                err_tick <= 1'b1;
              end
            end
          end
        end

        WAIT_ACK: begin
          cnt <= '0;
          // An ack coincident with the cfg_wr pulse belongs to no write yet and is ignored.
          if (bus.cfg_ack && !bus.cfg_wr) begin
            state     <= IDLE;
            bus.rx_en <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_teclado_eq.sv
// Randomised scoreboard bench for ctrl_teclado_eq: a key-level model queues expected cfg writes
// and error pulses, and a negedge monitor pops and compares whenever the DUT emits one.
module tb_ctrl_teclado_eq;

  localparam int G_W      = 4;
  localparam int GAIN_RST = 8;
  localparam int GAIN_MAX = 15;
  localparam int TIMEOUT  = 40;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           eq_run;
  logic [1:0]     banda_sel;
  logic [G_W-1:0] g_bajo;
  logic [G_W-1:0] g_medio;
  logic [G_W-1:0] g_alto;
  logic           err_tick;

  ctrl_teclado_eq_if #(.G_W(G_W)) bus ();

  ctrl_teclado_eq #(
    .G_W(G_W), .GAIN_RST(GAIN_RST), .GAIN_MAX(GAIN_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .eq_run         (eq_run),
    .banda_sel      (banda_sel),
    .ganancia_bajo  (g_bajo),
    .ganancia_medio (g_medio),
    .ganancia_alto  (g_alto),
    .err_tick       (err_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           is_wr;
    logic [1:0]     band;
    logic [G_W-1:0] gain;
  } ev_t;

  ev_t exp_q[$];
  ev_t got_ev;
  int  tests = 0;
  int  fails = 0;

  // Key-level reference: what each key press means, not how the sequencer encodes it.
  int m_gain[3];
  int m_sel;
  bit m_run;
  bit m_waiting;
  int m_prefix;  // 0: none, 1: after E0, 2: after F0 (next byte is a release)

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m_gain[i] = GAIN_RST;
    m_sel     = 0;
    m_run     = 1'b0;
    m_waiting = 1'b0;
    m_prefix  = 0;
    exp_q.delete();
  endfunction

  function automatic void push_err();
    ev_t e;
    e       = '0;
    e.is_wr = 1'b0;
    exp_q.push_back(e);
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    ev_t e;
    int  ng;
    if (m_waiting) return;
    if (m_prefix == 2) begin
      m_prefix = 0;
      return;
    end
    if (m_prefix == 1) begin
      m_prefix = 0;
      if (b == 8'h75 || b == 8'h72) begin
        ng = m_gain[m_sel] + ((b == 8'h75) ? 1 : -1);
        if (m_run && ng >= 0 && ng <= GAIN_MAX) begin
          m_gain[m_sel] = ng;
          e.is_wr = 1'b1;
          e.band  = 2'(m_sel);
          e.gain  = G_W'(ng);
          exp_q.push_back(e);
          m_waiting = 1'b1;
        end
      end else if (b == 8'hF0) begin
        m_prefix = 2;
      end else begin
        push_err();
      end
      return;
    end
    case (b)
      8'hF0:   m_prefix = 2;
      8'hE0:   m_prefix = 1;
      8'h43:   m_run = 1'b1;
      8'h2C:   m_run = 1'b0;
      8'h16:   m_sel = 0;
      8'h1E:   m_sel = 1;
      8'h26:   m_sel = 2;
      default: push_err();
    endcase
  endfunction

  function automatic void model_gap(input int n);
    if (m_prefix != 0 && n >= TIMEOUT) begin
      push_err();
      m_prefix = 0;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    model_byte(b);
    bus.rx_done_tick = 1'b1;
    bus.rx_data      = b;
    step();
    bus.rx_done_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    model_gap(n);
    for (int i = 0; i < n; i++) begin
      bus.rx_done_tick = 1'b0;
      bus.cfg_ack      = ($urandom_range(0, 3) == 0);
      step();
    end
    bus.cfg_ack = 1'b0;
  endtask

  // Entered in the cycle cfg_wr is high; holds ack off for wait_cyc cycles while ticks are dropped.
  task automatic do_ack(input int wait_cyc, input bit early);
    logic [1:0]     eb;
    logic [G_W-1:0] eg;
    eb = 2'(m_sel);
    eg = G_W'(m_gain[m_sel]);
    bus.cfg_ack = early;
    @(negedge clk);
    check("rx_en_during_wr", bus.rx_en, 0);
    step();
    for (int i = 0; i < wait_cyc; i++) begin
      bus.cfg_ack      = 1'b0;
      bus.rx_done_tick = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.rx_data      = (i == 0) ? 8'h72 : 8'($urandom);
      @(negedge clk);
      check("rx_en_wait_ack", bus.rx_en, 0);
      check("cfg_band_hold", bus.cfg_band, eb);
      check("cfg_gain_hold", bus.cfg_gain, eg);
      step();
    end
    bus.rx_done_tick = 1'b0;
    bus.cfg_ack      = 1'b1;
    step();
    bus.cfg_ack = 1'b0;
    m_waiting   = 1'b0;
    @(negedge clk);
    check("rx_en_after_ack", bus.rx_en, 1);
  endtask

  task automatic key(input logic [7:0] b);
    send(b);
    if (m_waiting) do_ack($urandom_range(0, 4), 1'($urandom_range(0, 1)));
  endtask

  task automatic check_state();
    @(negedge clk);
    check("gain_bajo", g_bajo, m_gain[0]);
    check("gain_medio", g_medio, m_gain[1]);
    check("gain_alto", g_alto, m_gain[2]);
    check("eq_run", eq_run, m_run);
    check("banda_sel", banda_sel, m_sel);
    check("rx_en_idle", bus.rx_en, 1);
  endtask

  // Monitor: every cfg_wr or err_tick pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (reset && (bus.cfg_wr || err_tick)) begin
      check("wr_err_exclusive", int'(bus.cfg_wr && err_tick), 0);
      check("event_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        got_ev = exp_q.pop_front();
        check("event_kind_is_wr", bus.cfg_wr, got_ev.is_wr);
        if (got_ev.is_wr) begin
          check("cfg_band", bus.cfg_band, got_ev.band);
          check("cfg_gain", bus.cfg_gain, got_ev.gain);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] codes [11];
  int         idx;
  int         gap;

  initial begin
    codes = '{8'hF0, 8'hE0, 8'hE0, 8'h43, 8'h2C, 8'h16, 8'h1E, 8'h26, 8'h75, 8'h72, 8'h55};
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
    bus.cfg_ack      = 1'b0;
    model_reset();

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_en", bus.rx_en, 0);
    check("rst_eq_run", eq_run, 0);
    check("rst_banda_sel", banda_sel, 0);
    check("rst_cfg_wr", bus.cfg_wr, 0);
    check("rst_cfg_band", bus.cfg_band, 0);
    check("rst_cfg_gain", bus.cfg_gain, 0);
    check("rst_err_tick", err_tick, 0);
    check("rst_gain_bajo", g_bajo, GAIN_RST);
    check("rst_gain_medio", g_medio, GAIN_RST);
    check("rst_gain_alto", g_alto, GAIN_RST);
    @(posedge clk);
    #1 reset = 1'b1;
    step();
    @(negedge clk);
    check("rx_en_after_release", bus.rx_en, 1);

    // Run, then select medio and step it up with a delayed ack and a dropped tick
    key(8'h43);
    check_state();
    send(8'h1E);
    send(8'hE0);
    send(8'h75);
    check("medio_after_up", g_medio, GAIN_RST + 1);
    do_ack(5, 1'b0);
    check_state();

    // Saturation at both ends
    key(8'h26);
    for (int i = 0; i < GAIN_MAX - GAIN_RST + 1; i++) begin
      key(8'hE0);
      key(8'h75);
    end
    check_state();
    check("alto_saturated", g_alto, GAIN_MAX);
    key(8'h16);
    for (int i = 0; i < GAIN_RST + 1; i++) begin
      key(8'hE0);
      key(8'h72);
    end
    check_state();
    check("bajo_floor", g_bajo, 0);

    // Releases produce no commands
    key(8'hF0);
    key(8'h43);
    key(8'hF0);
    key(8'h2C);
    key(8'hE0);
    key(8'hF0);
    key(8'h75);
    check_state();

    // Prefix timeout: err_tick exactly once, TIMEOUT idle cycles after the prefix
    send(8'hE0);
    model_gap(TIMEOUT + 1);
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      @(negedge clk);
      check("timeout_tick", err_tick, int'(k == TIMEOUT + 1));
      step();
    end
    key(8'h55);
    check_state();

    // Random key streams
    for (int it = 0; it < 400; it++) begin
      idx = $urandom_range(0, 11);
      if (idx == 11) key(8'($urandom));
      else key(codes[idx]);
      gap = ($urandom_range(0, 19) == 0) ? TIMEOUT + $urandom_range(1, 5) : $urandom_range(0, 3);
      idle(gap);
      check_state();
    end

    // Reset during WAIT_ACK aborts the write
    key(8'h43);
    key(8'h26);
    send(8'hE0);
    send((m_gain[2] < GAIN_MAX) ? 8'h75 : 8'h72);
    bus.cfg_ack = 1'b0;
    step();
    step();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("abort_rx_en", bus.rx_en, 0);
    check("abort_cfg_wr", bus.cfg_wr, 0);
    check("abort_eq_run", eq_run, 0);
    check("abort_gain_alto", g_alto, GAIN_RST);
    check("abort_banda_sel", banda_sel, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle(20);
    check_state();

    idle(5);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ctrl_teclado_eq.md
Name: ctrl_teclado_eq

Overview:
Command sequencer between the PS2 byte receiver and the equalizer datapath.
Decodes scan-code streams, including the E0 extended and F0 break prefixes, into run/stop, band select and gain up/down commands.
Keeps one gain register per band (bajo, medio, alto) and writes every gain change to the coefficient stage through a wr/ack handshake.
Gates the receiver through rx_en while a write is outstanding.

Parameters:
G_W, 4, gain width in bits
GAIN_RST, 8, gain value of every band after reset
GAIN_MAX, 15, upper saturation limit for gain
TIMEOUT, 50000, clk cycles allowed between a prefix byte and the next byte

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
rx_done_tick  in  1  one-cycle strobe: rx_data valid
rx_data  in  8  received scan-code byte
cfg_ack  in  1  coefficient stage accepted the write
rx_en  out  1  receiver enable
eq_run  out  1  equalizer running
banda_sel  out  2  selected band: 0 bajo, 1 medio, 2 alto
ganancia_bajo  out  G_W  gain, band 0
ganancia_medio  out  G_W  gain, band 1
ganancia_alto  out  G_W  gain, band 2
cfg_wr  out  1  one-cycle write strobe
cfg_band  out  2  band being written
cfg_gain  out  G_W  new gain being written
err_tick  out  1  one-cycle strobe: unknown code or timeout

Behaviour:
- All outputs are registered.
- Reset (reset=0, async): state IDLE; rx_en=0, eq_run=0, banda_sel=0, cfg_wr=0, cfg_band=0, cfg_gain=0, err_tick=0; all three gains=GAIN_RST; timeout counter=0.
- rx_en is 1 in IDLE, EXT, BRK and EXT_BRK, and 0 in WAIT_ACK. It goes to 1 on the first clk edge after reset is released.
- A byte is consumed only when rx_done_tick=1 and rx_en=1. A tick in WAIT_ACK is dropped silently.
- Latency: a byte consumed in cycle n produces its state and output effect at the edge ending cycle n.
- IDLE transitions:
  - F0 -> BRK.
  - E0 -> EXT.
  - 0x43 sets eq_run=1; 0x2C clears eq_run to 0. Both stay in IDLE.
  - 0x16, 0x1E, 0x26 set banda_sel to 0, 1, 2 respectively.
  - Any other byte: err_tick pulse, stay in IDLE.
- EXT transitions:
  - 0x75 (up) or 0x72 (down), with eq_run=1 and the target gain not already at its limit (GAIN_MAX for up, 0 for down): gain[banda_sel] changes by ±1 at the same edge. cfg_wr=1 for exactly one cycle with cfg_band=banda_sel and cfg_gain=the new value. Go to WAIT_ACK.
  - Up/down with eq_run=0, or with the gain already at its limit: no write, no error, go to IDLE. Gains saturate and never wrap.
  - F0 -> EXT_BRK.
  - Any other byte: err_tick pulse, go to IDLE.
- BRK and EXT_BRK: the next byte is discarded and the state returns to IDLE. Key releases never generate commands.
- Timeout:
  - The counter clears on every consumed byte and counts while in EXT, BRK or EXT_BRK.
  - On reaching TIMEOUT-1: go to IDLE with an err_tick pulse.
  - The counter is held at 0 in IDLE and WAIT_ACK.
- WAIT_ACK:
  - cfg_band and cfg_gain are held stable.
  - cfg_ack is sampled from the cycle after the cfg_wr pulse onward. cfg_ack=1 -> IDLE on the next edge.
  - No ack timeout: the block waits indefinitely.
  - cfg_ack outside WAIT_ACK, or in the same cycle as cfg_wr, is ignored.
- Reset asserted in WAIT_ACK aborts the write: gains return to GAIN_RST and no further cfg_wr is issued.
- err_tick and cfg_wr are never asserted in the same cycle.

Test Plan:
1. Reset, release, send 0x43 -> eq_run=1, rx_en=1, all gains=8, no err_tick.
2. eq_run=1, send 0x1E, then E0, then 0x75 -> banda_sel=1, ganancia_medio=9, one cfg_wr with cfg_band=1 and cfg_gain=9, rx_en=0. Hold ack 0 for 5 cycles and tick 0x72 meanwhile -> tick ignored. Assert ack -> IDLE, rx_en=1.
3. Raise ganancia_alto to 15 with acked writes, then send E0 75 -> no cfg_wr, gain stays 15. Send E0 72 from gain 0 -> stays 0, no cfg_wr.
4. Send F0 43 -> eq_run unchanged, no err_tick. Send E0 F0 75 -> no cfg_wr, state IDLE.
5. Send E0, then no byte for TIMEOUT cycles -> exactly one err_tick, state IDLE. Send 0x55 in IDLE -> one err_tick.
6. Issue a write, pull reset low while in WAIT_ACK -> outputs at reset values immediately, gains=8, no cfg_wr after release.
